// File: rtl/compare_pkg.sv
// compare_pkg -- shared types and sizing helpers for compare_sequencer.
//   state_t   : sequencer FSM states (IDLE/RUN/DONE)
//   res_t     : 2-bit compare result encoding (NONE/GT/EQ/LT)
//   num_slices: number of SLICE-wide slices in a WORDSIZE word
//   idx_width : width of the slice index, never less than 1
package compare_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   typedef enum logic [1:0] {RES_NONE, RES_GT, RES_EQ, RES_LT} res_t;

   function automatic int num_slices(input int wordsize, input int slice);
      return wordsize / slice;
   endfunction

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/compare_sequencer_if.sv
// compare_sequencer_if -- request/result handshake bundle of compare_sequencer.
//   request : in_valid, in_ready, input_a, input_b, is_signed
//   result  : res_valid, res_ready, greater, equal, less
//   master  : issue side (drives requests, accepts results)
//   slave   : the compare_sequencer itself
interface compare_sequencer_if #(
   parameter int WORDSIZE = 64
);
   logic                in_valid;
   logic                in_ready;
   logic [WORDSIZE-1:0] input_a;
   logic [WORDSIZE-1:0] input_b;
   logic                is_signed;
   logic                res_valid;
   logic                res_ready;
   logic                greater;
   logic                equal;
   logic                less;

   modport master (
      output in_valid, input_a, input_b, is_signed, res_ready,
      input  in_ready, res_valid, greater, equal, less
   );

   modport slave (
      input  in_valid, input_a, input_b, is_signed, res_ready,
      output in_ready, res_valid, greater, equal, less
   );
endinterface

// File: rtl/compare_sequencer_gt.sv
// compare_sequencer_gt -- unsigned greater-than flag for one W-bit slice.
//   a, b : slice operands
//   gt   : 1 when a > b (unsigned)
module compare_sequencer_gt #(
   parameter int W = 16
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         gt
);
   assign gt = (a > b);
endmodule

// File: rtl/compare_sequencer.sv
// compare_sequencer -- serial magnitude compare of two WORDSIZE operands,
// one SLICE-wide slice per clock, most-significant slice first.
//   clk, reset : clock, synchronous active-high reset
//   bus        : compare_sequencer_if.slave (request + result handshake)
// Build option COMPARE_EARLY_EXIT_EN: when defined the sequencer stops at
// the first unequal slice; otherwise it always walks all N slices and
// keeps the first unequal decision (same flags, fixed latency N).
// WORDSIZE must be an integer multiple of SLICE.
module compare_sequencer
   import compare_pkg::*;
#(
   parameter int WORDSIZE = 64,
   parameter int SLICE    = 16
) (
   input  logic                clk,
   input  logic                reset,
   compare_sequencer_if.slave  bus
);
   localparam int N  = num_slices(WORDSIZE, SLICE);
   localparam int IW = idx_width(N);
   localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);

   state_t                    state_q, state_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic [N-1:0][SLICE-1:0]   a_q, a_d, b_q, b_d;
   res_t                      res_q, res_d;
`ifndef COMPARE_EARLY_EXIT_EN
   res_t                      dec_q, dec_d;   // first unequal slice decision
`endif

   logic [WORDSIZE-1:0] sign_mask;
   logic [SLICE-1:0]    a_sl, b_sl;
   logic                gt_ab, gt_ba;
   res_t                slice_res;

   // Flipping the sign bit maps two's-complement order onto unsigned order.
   assign sign_mask = {bus.is_signed, {(WORDSIZE-1){1'b0}}};

   assign a_sl = a_q[idx_q];
   assign b_sl = b_q[idx_q];

   compare_sequencer_gt #(.W(SLICE)) u_gt_ab (.a(a_sl), .b(b_sl), .gt(gt_ab));
   compare_sequencer_gt #(.W(SLICE)) u_gt_ba (.a(b_sl), .b(a_sl), .gt(gt_ba));

   // Neither direction greater means the slices are equal.
   assign slice_res = gt_ab ? RES_GT : (gt_ba ? RES_LT : RES_EQ);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= IDX_TOP;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= RES_NONE;
`ifndef COMPARE_EARLY_EXIT_EN
         dec_q   <= RES_NONE;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
`ifndef COMPARE_EARLY_EXIT_EN
         dec_q   <= dec_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
`ifndef COMPARE_EARLY_EXIT_EN
      dec_d   = dec_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.input_a ^ sign_mask;
               b_d     = bus.input_b ^ sign_mask;
               idx_d   = IDX_TOP;
               state_d = RUN;
`ifndef COMPARE_EARLY_EXIT_EN
               dec_d   = RES_NONE;
`endif
            end
         end
         RUN: begin
`ifdef COMPARE_EARLY_EXIT_EN
            if (slice_res != RES_EQ || idx_q == '0) begin
               res_d   = slice_res;
               state_d = DONE;
            end else begin
               idx_d = idx_q - IW'(1);
            end
`else
            if (dec_q == RES_NONE && slice_res != RES_EQ)
               dec_d = slice_res;
            if (idx_q == '0) begin
               // Lower slices never override a decision already made above.
               res_d   = (dec_q != RES_NONE) ? dec_q : slice_res;
               state_d = DONE;
            end else begin
               idx_d = idx_q - IW'(1);
            end
`endif
         end
         DONE: begin
            if (bus.res_ready) begin
               res_d   = RES_NONE;
               idx_d   = IDX_TOP;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // res_q is RES_NONE everywhere except DONE, so flags are zero otherwise.
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.res_valid = (state_q == DONE);
   assign bus.greater   = (res_q == RES_GT);
   assign bus.equal     = (res_q == RES_EQ);
   assign bus.less      = (res_q == RES_LT);

endmodule
